ptr_cdc_sync: RTL and testbench
===============================

# ptr_cdc_sync

Parametrised Gray-pointer synchroniser for the async FIFO's pointer crossings. It supersedes the fixed 2/3-stage flop chain:
- supports 2–4 stages;
- converts the synchronised Gray pointer to binary;
- flags a warm-up/valid window after reset;
- pulses on pointer change;
- counts illegal multi-bit Gray transitions for CDC health monitoring.

One instance sits in each destination domain: write pointer into the read domain, and read pointer into the write domain.

## Interface
Parameters:
- ADDRESS_WIDTH, 4, FIFO address bits; pointer width is ADDRESS_WIDTH+1
- SYNC_STAGE, 2, number of synchroniser flops; legal 2..4, anything else is an elaboration error
- SOFT_RESET, 3, sw_rst honoured only when 2 or 3; otherwise ignored
- CHECK_EN, 1, 1 enables Gray-transition checking; 0 ties gray_err/err_cnt to 0

Ports:
- clk  input  1  destination-domain clock; all state on posedge clk
- hw_rst_n  input  1  asynchronous, active-low reset
- sw_rst  input  1  synchronous soft reset, active-high
- din  input  ADDRESS_WIDTH+1  Gray pointer from source domain, asynchronous to clk
- sync_gray  output  ADDRESS_WIDTH+1  synchronised Gray pointer
- sync_bin  output  ADDRESS_WIDTH+1  registered binary conversion of sync_gray
- ptr_valid  output  1  high once the chain has flushed after reset
- ptr_changed  output  1  one-cycle pulse when sync_bin takes a new value
- gray_err  output  1  sticky: a consecutive sync_gray pair differed in more than one bit
- err_cnt  output  8  saturating count of such events

## Operation
- Chain: stage[0] <= din; stage[k] <= stage[k-1]; sync_gray = stage[SYNC_STAGE-1] (registered).
- Conversion: sync_bin <= gray2bin(sync_gray); ptr_q holds the previous sync_gray.
- Warm-up: a counter of $clog2(SYNC_STAGE+2) bits counts cycles after reset release or sw_rst.
  - ptr_valid goes high when the count reaches SYNC_STAGE+1, then stays high.
  - The counter saturates there.
- ptr_changed: asserted when ptr_valid=1 and sync_bin's next value differs from its current value.
- Gray check: active only when CHECK_EN=1 and ptr_valid=1.
  - Flags when popcount(sync_gray ^ ptr_q) > 1.
  - On a flag: gray_err <= 1, and err_cnt increments, saturating at 255.
  - A difference of 0 or 1 bit is legal.
- Reset, hw_rst_n=0: every flop and output clears to 0 (chain, sync_gray, sync_bin, ptr_valid, ptr_changed, gray_err, err_cnt, warm-up counter).
- Soft reset, sw_rst=1 with SOFT_RESET ∈ {2,3}: same clear as hw_rst_n, on the clock edge. For any other SOFT_RESET value, sw_rst has no effect.
- Priority: hw_rst_n > sw_rst > normal update.
- sw_rst mid-operation drops ptr_valid and restarts warm-up.
- Wrap-around: the MSB toggle at pointer wrap is a single-bit Gray change. It is legal and produces ptr_changed.

## Timing
- A din change that is stable for ≥ SYNC_STAGE+1 clk edges appears on:
  - sync_gray after SYNC_STAGE edges;
  - sync_bin after SYNC_STAGE+1 edges.
- ptr_changed is high in exactly the cycle sync_bin first shows the new value.
- gray_err and err_cnt update one edge after the offending sync_gray value (they compare against ptr_q).
- ptr_valid rises SYNC_STAGE+1 edges after the first edge with reset inactive.
- Stable din produces no ptr_changed pulses.
- Back-to-back single-bit changes produce back-to-back pulses.

## Structure
- Package cdc_pkg holds:
  - function gray2bin, parametrised width;
  - function popcount_gt1;
  - localparams SYNC_STAGE_MIN=2, SYNC_STAGE_MAX=4, ERR_CNT_W=8.
- Sub-module cdc_sync_chain is the generate-based N-stage flop chain with the hw/sw reset handling. It is reused by other single-bit crossings.
- Top level holds the conversion, warm-up counter, change detect and checker.

## Test plan
- Reset/warm-up: SYNC_STAGE=3, din=5'b00110 held, release hw_rst_n.
  - All outputs 0 during reset.
  - sync_gray=00110 after 3 edges; sync_bin=00100 after 4 edges.
  - ptr_valid rises at edge 4; no gray_err.
- Gray count sweep: ADDRESS_WIDTH=4, din steps through Gray 0..31 and wraps, one step per 2 clk.
  - sync_bin = 0..31,0 in order, each delayed SYNC_STAGE+1.
  - One ptr_changed pulse per step.
  - err_cnt stays 0.
- Illegal transition: after ptr_valid, din 00000 -> 00011.
  - gray_err=1 and err_cnt=1 one edge after sync_gray=00011.
  - With CHECK_EN=0, both stay 0.
- Saturation: 300 alternating 00000/00011 transitions give err_cnt=255, not wrapping; gray_err stays 1.
- Soft reset: SOFT_RESET=3, sw_rst pulsed for one cycle mid-stream.
  - All outputs 0 the next cycle; ptr_valid relowers then recovers after SYNC_STAGE+1 edges.
  - Repeating with SOFT_RESET=1: sw_rst has no effect.
- Async reset mid-stream: hw_rst_n asserted between edges clears all outputs immediately, without waiting for clk. Simultaneous sw_rst and hw_rst_n behave as hw_rst_n.

Source files
------------

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared constants and helpers for pointer/bit CDC crossings
package cdc_pkg;

  localparam int SYNC_STAGE_MIN = 2;
  localparam int SYNC_STAGE_MAX = 4;
  localparam int ERR_CNT_W      = 8;
  localparam int CDC_MAX_W      = 32;

  // Zero-extended inputs convert correctly, so callers of any width up to
  // CDC_MAX_W cast in and truncate the result back out.
  function automatic logic [CDC_MAX_W-1:0] gray2bin(input logic [CDC_MAX_W-1:0] gray);
    logic [CDC_MAX_W-1:0] b;
    b[CDC_MAX_W-1] = gray[CDC_MAX_W-1];
    for (int i = CDC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray[i];
    end
    return b;
  endfunction

  function automatic logic popcount_gt1(input logic [CDC_MAX_W-1:0] v);
    return (v & (v - CDC_MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// rtl/cdc_sync_chain.sv - N-stage synchroniser flop chain with hard and soft clear
module cdc_sync_chain #(
  parameter int WIDTH     = 1,
  parameter int STAGES    = 2,
  parameter bit SW_RST_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sw_rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic                         soft_clr;

  assign soft_clr = SW_RST_EN && sw_rst_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (soft_clr) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ptr_cdc_sync.sv
// rtl/ptr_cdc_sync.sv - Gray pointer synchroniser with binary output, warm-up flag and Gray health check
module ptr_cdc_sync
  import cdc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGE    = 2,
  parameter int SOFT_RESET    = 3,
  parameter int CHECK_EN      = 1
) (
  input  logic                     clk,
  input  logic                     hw_rst_n,
  input  logic                     sw_rst,
  input  logic [ADDRESS_WIDTH:0]   din,
  output logic [ADDRESS_WIDTH:0]   sync_gray,
  output logic [ADDRESS_WIDTH:0]   sync_bin,
  output logic                     ptr_valid,
  output logic                     ptr_changed,
  output logic                     gray_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam int                PTR_W    = ADDRESS_WIDTH + 1;
  localparam int                CNT_W    = $clog2(SYNC_STAGE + 2);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(SYNC_STAGE + 1);
  localparam bit                SW_EN    = (SOFT_RESET == 2) || (SOFT_RESET == 3);

  if (SYNC_STAGE < SYNC_STAGE_MIN || SYNC_STAGE > SYNC_STAGE_MAX) begin : g_bad_stage
    $error("ptr_cdc_sync: SYNC_STAGE must be within 2..4");
  end

  logic             soft_clr;
  logic [PTR_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_q, changed_d;

  assign soft_clr = SW_EN && sw_rst;

  cdc_sync_chain #(
    .WIDTH     (PTR_W),
    .STAGES    (SYNC_STAGE),
    .SW_RST_EN (SW_EN)
  ) u_chain (
    .clk_i    (clk),
    .rst_ni   (hw_rst_n),
    .sw_rst_i (sw_rst),
    .d_i      (din),
    .q_o      (sync_gray)
  );

  assign ptr_valid = (cnt_q == CNT_DONE);

  always_comb begin
    bin_d     = PTR_W'(gray2bin(CDC_MAX_W'(sync_gray)));
    cnt_d     = ptr_valid ? cnt_q : cnt_q + CNT_W'(1);
    changed_d = ptr_valid && (bin_d != bin_q);
  end

  always_ff @(posedge clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      bin_q     <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else if (soft_clr) begin
      bin_q     <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign sync_bin    = bin_q;
  assign ptr_changed = changed_q;

  if (CHECK_EN != 0) begin : g_check
    logic [PTR_W-1:0]     ptr_q;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 flag;

    // Checking waits for warm-up so the chain filling from zero is not flagged.
    always_comb begin
      flag      = ptr_valid && popcount_gt1(CDC_MAX_W'(sync_gray ^ ptr_q));
      err_d     = err_q | flag;
      err_cnt_d = (flag && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge hw_rst_n) begin
      if (!hw_rst_n) begin
        ptr_q     <= '0;
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end else if (soft_clr) begin
        ptr_q     <= '0;
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end else begin
        ptr_q     <= sync_gray;
        err_q     <= err_d;
        err_cnt_q <= err_cnt_d;
      end
    end

    assign gray_err = err_q;
    assign err_cnt  = err_cnt_q;
  end else begin : g_no_check
    assign gray_err = 1'b0;
    assign err_cnt  = '0;
  end

endmodule

// File: tb/tb_ptr_cdc_sync.sv
// tb/tb_ptr_cdc_sync.sv - self-checking bench for ptr_cdc_sync against a delay-history reference model
module tb_ptr_cdc_sync;

  localparam int AW   = 4;
  localparam int PW   = AW + 1;
  localparam int NI   = 4;
  localparam int HMAX = 4096;
  localparam int STG  [NI] = '{3, 3, 2, 4};
  localparam bit SWEN [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit CHK  [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic          clk      = 1'b0;
  logic          hw_rst_n = 1'b0;
  logic          sw_rst   = 1'b0;
  logic [PW-1:0] din      = '0;

  logic [PW-1:0] sg [NI];
  logic [PW-1:0] sb [NI];
  logic          pv [NI];
  logic          pc [NI];
  logic          ge [NI];
  logic [7:0]    ec [NI];

  ptr_cdc_sync #(.ADDRESS_WIDTH(AW), .SYNC_STAGE(3), .SOFT_RESET(3), .CHECK_EN(1)) u_dut0 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din), .sync_gray(sg[0]), .sync_bin(sb[0]),
    .ptr_valid(pv[0]), .ptr_changed(pc[0]), .gray_err(ge[0]), .err_cnt(ec[0]));
  ptr_cdc_sync #(.ADDRESS_WIDTH(AW), .SYNC_STAGE(3), .SOFT_RESET(1), .CHECK_EN(1)) u_dut1 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din), .sync_gray(sg[1]), .sync_bin(sb[1]),
    .ptr_valid(pv[1]), .ptr_changed(pc[1]), .gray_err(ge[1]), .err_cnt(ec[1]));
  ptr_cdc_sync #(.ADDRESS_WIDTH(AW), .SYNC_STAGE(2), .SOFT_RESET(2), .CHECK_EN(0)) u_dut2 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din), .sync_gray(sg[2]), .sync_bin(sb[2]),
    .ptr_valid(pv[2]), .ptr_changed(pc[2]), .gray_err(ge[2]), .err_cnt(ec[2]));
  ptr_cdc_sync #(.ADDRESS_WIDTH(AW), .SYNC_STAGE(4), .SOFT_RESET(0), .CHECK_EN(1)) u_dut3 (
    .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .din(din), .sync_gray(sg[3]), .sync_bin(sb[3]),
    .ptr_valid(pv[3]), .ptr_changed(pc[3]), .gray_err(ge[3]), .err_cnt(ec[3]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: din sampled at every counted edge since the last clear; all outputs
  // are pure functions of that history and the stage delay.
  logic [PW-1:0] hist [NI][HMAX];
  int            n    [NI];
  int            errm [NI];

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input int v);
    logic [PW-1:0] x;
    x = PW'(v);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [PW-1:0] m_sg(input int i, input int m);
    if (m >= STG[i]) return hist[i][m - STG[i]];
    return '0;
  endfunction

  function automatic logic [PW-1:0] m_sb(input int i, input int m);
    if (m >= STG[i] + 1) return g2b(hist[i][m - STG[i] - 1]);
    return '0;
  endfunction

  function automatic logic m_pv(input int i, input int m);
    return m >= STG[i] + 1;
  endfunction

  function automatic logic m_pc(input int i, input int m);
    return (m - 1 >= STG[i] + 1) && (m_sb(i, m) != m_sb(i, m - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int i);
    n[i]    = 0;
    errm[i] = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (!hw_rst_n || (sw_rst && SWEN[i])) begin
        model_clear(i);
      end else if (n[i] < HMAX) begin
        hist[i][n[i]] = din;
        n[i]++;
        if (CHK[i] && (n[i] - 1 >= STG[i] + 1) && errm[i] < 255 &&
            $countones(m_sg(i, n[i] - 1) ^ m_sg(i, n[i] - 2)) > 1)
          errm[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("sync_gray%0d", i),   32'(sg[i]), 32'(m_sg(i, n[i])));
      check($sformatf("sync_bin%0d", i),    32'(sb[i]), 32'(m_sb(i, n[i])));
      check($sformatf("ptr_valid%0d", i),   32'(pv[i]), 32'(m_pv(i, n[i])));
      check($sformatf("ptr_changed%0d", i), 32'(pc[i]), 32'(m_pc(i, n[i])));
      check($sformatf("gray_err%0d", i),    32'(ge[i]), 32'(errm[i] > 0));
      check($sformatf("err_cnt%0d", i),     32'(ec[i]), 32'(errm[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int k);
    for (int j = 0; j < k; j++) tick();
  endtask

  task automatic hard_restart(input logic [PW-1:0] v);
    hw_rst_n = 1'b0;
    din      = v;
    tick();
    hw_rst_n = 1'b1;
    ticks(6);
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < NI; i++) model_clear(i);

    // Reset and warm-up with a held pointer
    din = 5'b00110;
    ticks(3);
    hw_rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) begin
        check("warm_sg_e3", 32'(sg[0]), 32'h06);
        check("warm_pv_e3", 32'(pv[0]), 32'h0);
      end
      if (k == 4) begin
        check("warm_sb_e4", 32'(sb[0]), 32'h04);
        check("warm_pv_e4", 32'(pv[0]), 32'h1);
        check("warm_ge_e4", 32'(ge[0]), 32'h0);
      end
    end

    // Gray count sweep with wrap
    hard_restart('0);
    pulses = 0;
    for (int v = 1; v <= 32; v++) begin
      din = b2g(v);
      for (int r = 0; r < 2; r++) begin
        tick();
        pulses += int'(pc[0]);
      end
    end
    for (int r = 0; r < 5; r++) begin
      tick();
      pulses += int'(pc[0]);
    end
    check("sweep_pulses", 32'(pulses), 32'd32);
    check("sweep_errcnt", 32'(ec[0]), 32'd0);

    // Randomized single-bit steps, arbitrary jumps and occasional soft resets
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) != 0) din = din ^ PW'(1 << $urandom_range(0, PW - 1));
      else                           din = PW'($urandom);
      sw_rst = ($urandom_range(0, 39) == 0);
      tick();
      sw_rst = 1'b0;
      ticks($urandom_range(0, 3));
    end

    // Illegal two-bit transition
    hard_restart('0);
    din = 5'b00011;
    ticks(3);
    check("illegal_sg", 32'(sg[0]), 32'h03);
    check("illegal_ge_before", 32'(ge[0]), 32'h0);
    tick();
    check("illegal_ge_after", 32'(ge[0]), 32'h1);
    check("illegal_cnt_after", 32'(ec[0]), 32'h1);
    check("nochk_ge", 32'(ge[2]), 32'h0);
    check("nochk_cnt", 32'(ec[2]), 32'h0);

    // Error counter saturation
    for (int it = 0; it < 300; it++) begin
      din = (it % 2 == 0) ? 5'b00000 : 5'b00011;
      tick();
    end
    ticks(6);
    check("sat_cnt", 32'(ec[0]), 32'd255);
    check("sat_ge", 32'(ge[0]), 32'h1);

    // Soft reset mid-stream
    din = 5'b01100;
    ticks(6);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("soft_pv0", 32'(pv[0]), 32'h0);
    check("soft_sg0", 32'(sg[0]), 32'h0);
    check("soft_cnt0", 32'(ec[0]), 32'h0);
    check("soft_ignored_pv1", 32'(pv[1]), 32'h1);
    check("soft_ignored_cnt1", 32'(ec[1]), 32'd255);
    ticks(3);
    check("soft_pv0_e3", 32'(pv[0]), 32'h0);
    tick();
    check("soft_pv0_e4", 32'(pv[0]), 32'h1);

    // Asynchronous reset between edges, together with sw_rst
    ticks(2);
    #3;
    hw_rst_n = 1'b0;
    sw_rst   = 1'b1;
    for (int i = 0; i < NI; i++) model_clear(i);
    #1;
    compare_all();
    check("async_pv1", 32'(pv[1]), 32'h0);
    check("async_cnt1", 32'(ec[1]), 32'h0);
    check("async_sb3", 32'(sb[3]), 32'h0);
    ticks(3);
    hw_rst_n = 1'b1;
    tick();
    sw_rst = 1'b0;
    ticks(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
